// File: rtl/coin_credit_unit.sv
// -----------------------------------------------------------------------------
// coin_credit_unit
//
// Payment front-end for the coin-operated washer. Accumulates credit from the
// 50-cent and 1-real buttons, hands the washer a single-cycle start pulse
// (moeda), returns change or refunds as troco_pulse pulses, and refuses coins
// while a paid cycle is pending or running.
//
// Handshake: moeda, troco_pulse and rejeita are one-clock event pulses, all
// registered. Each high cycle is one event; there is no back-pressure.
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous, active-low reset
//   botao_50cent  in   50-cent coin button (async level, debounced upstream)
//   botao_1real   in   1-real coin button (async level, debounced upstream)
//   cancelar      in   synchronous refund request (level)
//   machine_idle  in   1 = washer controller sits in ESPERA
//   moeda         out  start pulse to the washer, one clk wide
//   credit        out  current credit in 50-cent units
//   troco_pulse   out  one pulse per 50 cents returned
//   rejeita       out  one-clk pulse when a coin is refused
//   aceitar       out  coins are being accepted (panel lamp)
//   state_o       out  current FSM state (debug observation)
// -----------------------------------------------------------------------------
module coin_credit_unit #(
    parameter int PRICE       = 4,
    parameter int CREDIT_W    = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int TMR_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                botao_50cent,
    input  logic                botao_1real,
    input  logic                cancelar,
    input  logic                machine_idle,
    output logic                moeda,
    output logic [CREDIT_W-1:0] credit,
    output logic                troco_pulse,
    output logic                rejeita,
    output logic                aceitar,
    output logic [2:0]          state_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACUMULA  = 3'd1,
        PAGO     = 3'd2,
        TROCO    = 3'd3,
        BLOQUEIO = 3'd4
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [TMR_W-1:0]    TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

    state_t state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic phase_q, phase_d;          // TROCO: 1 = low half of a pulse pair
    logic from_pago_q, from_pago_d;  // TROCO exit target selector
    logic busy_seen_q, busy_seen_d;  // BLOQUEIO: washer has left ESPERA
    logic moeda_q, moeda_d;
    logic troco_q, troco_d;
    logic rejeita_q, rejeita_d;
    logic aceitar_q, aceitar_d;

    // Two-flop synchronizers plus a third flop for rising-edge detection
    logic b50_meta_q, b50_sync_q, b50_prev_q;
    logic b1r_meta_q, b1r_sync_q, b1r_prev_q;

    logic                b50_edge, b1r_edge;
    logic [1:0]          coin_val;
    logic                coin_det;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic [CREDIT_W-1:0] remain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b50_meta_q <= 1'b0;
            b50_sync_q <= 1'b0;
            b50_prev_q <= 1'b0;
            b1r_meta_q <= 1'b0;
            b1r_sync_q <= 1'b0;
            b1r_prev_q <= 1'b0;
        end else begin
            b50_meta_q <= botao_50cent;
            b50_sync_q <= b50_meta_q;
            b50_prev_q <= b50_sync_q;
            b1r_meta_q <= botao_1real;
            b1r_sync_q <= b1r_meta_q;
            b1r_prev_q <= b1r_sync_q;
        end
    end

    assign b50_edge = b50_sync_q & ~b50_prev_q;
    assign b1r_edge = b1r_sync_q & ~b1r_prev_q;

    // 50c = 1 unit, 1 real = 2 units, both together = 3 units
    assign coin_val  = {b1r_edge, b50_edge};
    assign coin_det  = |coin_val;
    assign coin_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
    assign coin_fits = ~coin_sum[CREDIT_W];
    assign remain    = credit_q - PRICE_C;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            credit_q    <= '0;
            timer_q     <= '0;
            phase_q     <= 1'b0;
            from_pago_q <= 1'b0;
            busy_seen_q <= 1'b0;
            moeda_q     <= 1'b0;
            troco_q     <= 1'b0;
            rejeita_q   <= 1'b0;
            aceitar_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            timer_q     <= timer_d;
            phase_q     <= phase_d;
            from_pago_q <= from_pago_d;
            busy_seen_q <= busy_seen_d;
            moeda_q     <= moeda_d;
            troco_q     <= troco_d;
            rejeita_q   <= rejeita_d;
            aceitar_q   <= aceitar_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        timer_d     = timer_q;
        phase_d     = phase_q;
        from_pago_d = from_pago_q;
        busy_seen_d = busy_seen_q;
        moeda_d     = 1'b0;
        troco_d     = 1'b0;
        rejeita_d   = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d     = '0;
                phase_d     = 1'b0;
                from_pago_d = 1'b0;
                busy_seen_d = 1'b0;
                if (coin_det) begin
                    if (coin_fits) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = ACUMULA;
                    end else begin
                        rejeita_d = 1'b1;
                    end
                end
            end

            ACUMULA: begin
                if (coin_det) begin
                    timer_d = '0;
                    if (coin_fits) credit_d = coin_sum[CREDIT_W-1:0];
                    else           rejeita_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                // Payment check uses the registered credit and wins over refund;
                // a coin arriving in the same cycle still lands in credit_d.
                if (credit_q >= PRICE_C) begin
                    state_d = PAGO;
                end else if (cancelar || (!coin_det && timer_q == TMO_LAST)) begin
                    state_d     = TROCO;
                    phase_d     = 1'b0;
                    from_pago_d = 1'b0;
                end
            end

            PAGO: begin
                if (coin_det) rejeita_d = 1'b1;
                if (machine_idle) begin
                    moeda_d  = 1'b1;
                    credit_d = remain;
                    if (remain != '0) begin
                        state_d     = TROCO;
                        phase_d     = 1'b0;
                        from_pago_d = 1'b1;
                    end else begin
                        state_d     = BLOQUEIO;
                        busy_seen_d = 1'b0;
                    end
                end
            end

            TROCO: begin
                if (coin_det) rejeita_d = 1'b1;
                if (!phase_q) begin
                    if (credit_q == '0) begin
                        state_d     = from_pago_q ? BLOQUEIO : IDLE;
                        busy_seen_d = 1'b0;
                    end else begin
                        troco_d  = 1'b1;
                        credit_d = credit_q - 1'b1;
                        phase_d  = 1'b1;
                    end
                end else begin
                    phase_d = 1'b0;
                end
            end

            BLOQUEIO: begin
                if (coin_det) rejeita_d = 1'b1;
                if (!machine_idle)    busy_seen_d = 1'b1;
                else if (busy_seen_q) state_d     = IDLE;
            end

            default: state_d = IDLE;
        endcase

        aceitar_d = (state_d == IDLE) || (state_d == ACUMULA);
    end

    assign moeda       = moeda_q;
    assign credit      = credit_q;
    assign troco_pulse = troco_q;
    assign rejeita     = rejeita_q;
    assign aceitar     = aceitar_q;
    assign state_o     = state_q;

endmodule
